sdc_sector_server: RTL and testbench

//  Responder side of the core's sector-request interface (sdc_rd/sdc_sector in, busy/done/byte strobes out).

---
 rtl/sdc_sector_server_if.sv | 30 +++
 rtl/sdc_sector_server.sv | 90 +++++++++
 tb/tb_sdc_sector_server.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/sdc_sector_server_if.sv
// sdc_sector_server_if: core-side sector request/stream signals plus the byte-wide backing-memory read port
interface sdc_sector_server_if #(
  parameter int DRIVES = 4,
  parameter int MEM_AW = 24
);
  logic [DRIVES-1:0]        sdc_rd;
  logic [31:0]              sdc_sector;
  logic [DRIVES*MEM_AW-1:0] img_base;
  logic [DRIVES*32-1:0]     img_size;
  logic                     sdc_busy;
  logic                     sdc_done;
  logic                     sdc_err;
  logic                     sdc_byte_in_strobe;
  logic [8:0]               sdc_byte_in_addr;
  logic [7:0]               sdc_byte_in_data;
  logic                     mem_req;
  logic [MEM_AW-1:0]        mem_addr;
  logic                     mem_ack;
  logic [7:0]               mem_data;
  modport master (
    output sdc_rd, sdc_sector, img_base, img_size, mem_ack, mem_data,
    input  sdc_busy, sdc_done, sdc_err, sdc_byte_in_strobe, sdc_byte_in_addr, sdc_byte_in_data,
           mem_req, mem_addr
  );
  modport slave (
    input  sdc_rd, sdc_sector, img_base, img_size, mem_ack, mem_data,
    output sdc_busy, sdc_done, sdc_err, sdc_byte_in_strobe, sdc_byte_in_addr, sdc_byte_in_data,
           mem_req, mem_addr
  );
endinterface

// File: rtl/sdc_sector_server.sv
// sdc_sector_server: serves 512-byte sectors of mounted drive images from a byte-wide backing memory
// as addressed byte strobes, one request at a time, lowest requesting armed drive first.
module sdc_sector_server #(
  parameter int DRIVES     = 4,
  parameter int MEM_AW     = 24,
  parameter int STROBE_GAP = 2
) (
  input logic clk_sys,
  input logic reset_n,
  sdc_sector_server_if.slave bus
);
  localparam int DW = DRIVES > 1 ? $clog2(DRIVES) : 1;
  localparam int GW = STROBE_GAP > 1 ? $clog2(STROBE_GAP) : 1;
  typedef enum logic [2:0] {S_IDLE, S_CHECK, S_FETCH, S_STROBE, S_GAP, S_DONE} state_t;
  state_t            r_state, w_next;
  logic [DRIVES-1:0] r_armed, w_elig, w_pick;
  logic [DW-1:0]     r_drv, w_pick_idx;
  logic [31:0]       r_sector, w_size;
  logic [8:0]        r_idx, r_addr_out;
  logic [7:0]        r_data_out;
  logic [GW-1:0]     r_gap;
  logic              r_err, w_accept, w_oob, w_gap_end;
  logic [40:0]       w_off;
  logic [41:0]       w_end;
  logic [MEM_AW-1:0] w_base, w_addr;
  assign w_elig = bus.sdc_rd & r_armed;
  always_comb begin
    w_pick_idx = '0;
    for (int i = DRIVES - 1; i >= 0; i--) w_pick_idx = w_elig[i] ? DW'(i) : w_pick_idx;
  end
  assign w_accept  = r_state == S_IDLE && |w_elig;
  assign w_pick    = w_accept ? DRIVES'(1) << w_pick_idx : '0;
  assign w_base    = bus.img_base[r_drv*MEM_AW +: MEM_AW];
  assign w_size    = bus.img_size[r_drv*32 +: 32];
  // full-width sector end so huge sector numbers cannot alias into range
  assign w_off     = {r_sector, 9'b0};
  assign w_end     = {1'b0, w_off} + 42'd512;
  assign w_oob     = w_end > {10'b0, w_size};
  assign w_addr    = w_base + w_off[MEM_AW-1:0] + MEM_AW'(r_idx);
  assign w_gap_end = r_gap == GW'(STROBE_GAP - 1);
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   w_next = w_accept ? S_CHECK : S_IDLE;
      S_CHECK:  w_next = w_oob ? S_DONE : S_FETCH;
      S_FETCH:  w_next = bus.mem_ack ? S_STROBE : S_FETCH;
      S_STROBE: w_next = S_GAP;
      S_GAP:    w_next = !w_gap_end ? S_GAP : &r_idx ? S_DONE : S_FETCH;
      default:  w_next = S_IDLE;
    endcase
  end
  assign bus.sdc_busy           = r_state inside {S_CHECK, S_FETCH, S_STROBE, S_GAP};
  assign bus.sdc_done           = r_state == S_DONE;
  assign bus.sdc_err            = r_state == S_DONE && r_err;
  assign bus.sdc_byte_in_strobe = r_state == S_STROBE;
  assign bus.sdc_byte_in_addr   = r_addr_out;
  assign bus.sdc_byte_in_data   = r_data_out;
  assign bus.mem_req            = r_state == S_FETCH;
  assign bus.mem_addr           = bus.mem_req ? w_addr : '0;
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_armed    <= '1;
      r_drv      <= '0;
      r_sector   <= '0;
      r_idx      <= '0;
      r_addr_out <= '0;
      r_data_out <= '0;
      r_gap      <= '0;
      r_err      <= 1'b0;
    end else begin
      r_state <= w_next;
      // a low request bit re-arms its drive, so a held request is served only once
      r_armed <= (r_armed & ~w_pick) | ~bus.sdc_rd;
      r_gap   <= r_state == S_GAP ? r_gap + 1'b1 : '0;
      if (w_accept) begin
        r_drv    <= w_pick_idx;
        r_sector <= bus.sdc_sector;
        r_idx    <= '0;
        r_err    <= 1'b0;
      end
      if (r_state == S_CHECK) r_err <= w_oob;
      if (r_state == S_FETCH && bus.mem_ack) begin
        r_addr_out <= r_idx;
        r_data_out <= bus.mem_data;
      end
      if (r_state == S_GAP && w_gap_end && !(&r_idx)) r_idx <= r_idx + 1'b1;
    end
  end
endmodule

// File: tb/tb_sdc_sector_server.sv
// tb_sdc_sector_server: directed and randomized sector requests checked against a transaction-level model
// of expected strobes, memory addresses and done/err outcomes.
module tb_sdc_sector_server;
  localparam int DRIVES = 4, MEM_AW = 24, GAP = 2;
  logic clk_sys = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk_sys = ~clk_sys;
  sdc_sector_server_if #(.DRIVES(DRIVES), .MEM_AW(MEM_AW)) bus ();
  sdc_sector_server #(.DRIVES(DRIVES), .MEM_AW(MEM_AW), .STROBE_GAP(GAP)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .bus(bus)
  );
  typedef struct {logic [8:0] a; logic [7:0] d; logic [23:0] m;} exp_t;
  exp_t        exp_q[$];
  bit          exp_err_q[$];
  logic [23:0] base [4];
  logic [31:0] size [4];
  logic [31:0] sec  [4];
  bit          armed[4] = '{1, 1, 1, 1};
  int n_checks = 0, n_err = 0;
  int cyc = 0, last_strobe = -100, busy_run = 0, strobe_cnt = 0, done_cnt = 0;
  int first_data = 0, last_data = 0, first_maddr = 0;
  logic prev_ack = 1'b0;
  int  ack_delay = 0, fixed_delay = 0;
  bit  rand_delay = 0;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask
  function automatic logic [23:0] model_addr(input int d, input logic [31:0] s, input int i);
    return 24'(64'(base[d]) + (64'(s) << 9) + 64'(i));
  endfunction
  task automatic expect_sector(input int d, input logic [31:0] s);
    logic [23:0] m;
    if ((64'(s) << 9) + 64'd512 > 64'(size[d])) exp_err_q.push_back(1'b1);
    else begin
      for (int i = 0; i < 512; i++) begin
        m = model_addr(d, s, i);
        exp_q.push_back('{9'(i), m[7:0] ^ 8'h5A, m});
      end
      exp_err_q.push_back(1'b0);
    end
  endtask
  task automatic apply_imgs();
    for (int d = 0; d < 4; d++) begin
      bus.img_base[d*MEM_AW +: MEM_AW] = base[d];
      bus.img_size[d*32 +: 32]         = size[d];
    end
  endtask
  // backing memory: mem[a] = a[7:0] ^ 0x5A, acked after a programmable number of request cycles
  initial begin
    bus.mem_ack  = 1'b0;
    bus.mem_data = '0;
    forever begin
      int wcnt;
      @(posedge clk_sys);
      #1;
      bus.mem_ack = 1'b0;
      if (!bus.mem_req) wcnt = 0;
      else if (wcnt >= ack_delay) begin
        bus.mem_ack  = 1'b1;
        bus.mem_data = bus.mem_addr[7:0] ^ 8'h5A;
        wcnt         = 0;
        ack_delay    = rand_delay ? int'($urandom_range(0, 2)) : fixed_delay;
      end else wcnt++;
    end
  end
  always @(negedge clk_sys) begin
    exp_t e;
    bit   ee;
    cyc++;
    if (!reset_n) begin
      prev_ack    = 1'b0;
      last_strobe = -100;
      busy_run    = 0;
    end else begin
      chk("strobe_follows_ack", bus.sdc_byte_in_strobe, prev_ack);
      chk("err_only_with_done", bus.sdc_err & ~bus.sdc_done, 0);
      if (bus.sdc_byte_in_strobe) begin
        chk("strobe_expected", exp_q.size() > 0, 1);
        chk("busy_during_strobe", bus.sdc_busy, 1);
        chk("strobe_spacing", cyc - last_strobe >= GAP + 2, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("byte_addr", bus.sdc_byte_in_addr, e.a);
          chk("byte_data", bus.sdc_byte_in_data, e.d);
        end
        if (bus.sdc_byte_in_addr == 0) first_data = bus.sdc_byte_in_data;
        if (bus.sdc_byte_in_addr == 511) last_data = bus.sdc_byte_in_data;
        last_strobe = cyc;
        strobe_cnt++;
      end
      if (bus.mem_req) begin
        chk("mem_req_expected", exp_q.size() > 0, 1);
        chk("busy_during_fetch", bus.sdc_busy, 1);
        if (exp_q.size() > 0) chk("mem_addr", bus.mem_addr, exp_q[0].m);
        if (exp_q.size() == 512) first_maddr = bus.mem_addr;
      end
      if (bus.sdc_done) begin
        chk("done_expected", exp_err_q.size() > 0, 1);
        chk("busy_low_at_done", bus.sdc_busy, 0);
        chk("all_bytes_before_done", exp_q.size(), 0);
        if (exp_err_q.size() > 0) begin
          ee = exp_err_q.pop_front();
          chk("done_err", bus.sdc_err, ee);
          if (ee) chk("err_busy_len", busy_run, 1);
        end
        done_cnt++;
        last_strobe = -100;
        busy_run    = 0;
      end else busy_run = bus.sdc_busy ? busy_run + 1 : 0;
      prev_ack = bus.mem_ack;
    end
  end
  task automatic wait_busy();
    int k = 0;
    while (!bus.sdc_busy && k < 50) begin @(negedge clk_sys); k++; end
    chk("accept_seen", bus.sdc_busy, 1);
  endtask
  task automatic wait_done();
    int k = 0;
    do begin @(negedge clk_sys); k++; end while (!bus.sdc_done && k < 20000);
    chk("done_seen", bus.sdc_done, 1);
  endtask
  task automatic serve(input logic [3:0] mask);
    int order[$];
    for (int d = 0; d < 4; d++) begin
      if (!bus.sdc_rd[d]) armed[d] = 1;
      if (mask[d] && armed[d]) order.push_back(d);
    end
    if (order.size() > 0) begin
      bus.sdc_sector = sec[order[0]];
      expect_sector(order[0], sec[order[0]]);
    end
    bus.sdc_rd = mask;
    foreach (order[k]) begin
      if (k > 0) begin
        #1;
        bus.sdc_sector = sec[order[k]];
        expect_sector(order[k], sec[order[k]]);
      end
      wait_busy();
      armed[order[k]] = 0;
      bus.sdc_sector  = $urandom;
      wait_done();
    end
    if (order.size() == 0) repeat (20) @(negedge clk_sys);
    #1;
  endtask
  task automatic release_rd();
    bus.sdc_rd = '0;
    @(negedge clk_sys);
  endtask
  initial begin
    int d0, s0, k, seen;
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end
  initial begin
    int d0, s0, k, seen;
    bus.sdc_rd     = '0;
    bus.sdc_sector = '0;
    base = '{24'h100000, 24'h200000, 24'h3F0000, 24'hFFFF00};
    size = '{32'h1000, 32'h20000, 32'h800, 32'hFFFFFFFF};
    apply_imgs();
    #2 reset_n = 1'b0;
    #1 chk("reset_outputs_zero", {bus.sdc_busy, bus.sdc_done, bus.sdc_err, bus.sdc_byte_in_strobe,
        bus.sdc_byte_in_addr, bus.sdc_byte_in_data, bus.mem_req, bus.mem_addr}, 0);
    repeat (3) @(negedge clk_sys);
    reset_n = 1'b1;
    chk("model_pin_addr", model_addr(0, 3, 511), 24'h1007FF);
    // single good sector from drive 0
    sec = '{32'd3, 32'd0, 32'd0, 32'd0};
    d0 = done_cnt;
    serve(4'b0001);
    chk("t1_done_count", done_cnt - d0, 1);
    chk("t1_first_data", first_data, 8'h5A);
    chk("t1_last_data", last_data, 8'hA5);
    chk("t1_first_mem_addr", first_maddr, 24'h100600);
    // simultaneous requests: lower drive first, then the other
    release_rd();
    sec = '{32'd0, 32'd7, 32'd2, 32'd0};
    d0 = done_cnt;
    serve(4'b0110);
    chk("t2_done_count", done_cnt - d0, 2);
    // out-of-range sectors, including ones only a full-width compare rejects, then the last valid sector
    release_rd();
    size[0] = 32'd1024;
    apply_imgs();
    sec = '{32'd2, 32'd0, 32'd0, 32'hFFFFFFFF};
    serve(4'b1001);
    release_rd();
    sec[3] = 32'h7FFFFF;
    serve(4'b1000);
    release_rd();
    sec[0] = 32'd1;
    s0 = strobe_cnt;
    serve(4'b0001);
    chk("t3_boundary_strobes", strobe_cnt - s0, 512);
    // slow memory
    release_rd();
    fixed_delay = 7;
    ack_delay   = 7;
    sec[1] = 32'd5;
    s0 = strobe_cnt;
    serve(4'b0010);
    chk("t4_strobes", strobe_cnt - s0, 512);
    fixed_delay = 0;
    ack_delay   = 0;
    // held request must not restart
    seen = 0;
    repeat (2000) begin @(negedge clk_sys); seen |= bus.sdc_busy; end
    chk("t5_held_no_restart", seen, 0);
    release_rd();
    d0 = done_cnt;
    sec[1] = 32'd9;
    serve(4'b0010);
    chk("t5_rearm_transfer", done_cnt - d0, 1);
    // reset mid-transfer
    release_rd();
    sec[0] = 32'd1;
    bus.sdc_sector = sec[0];
    expect_sector(0, sec[0]);
    bus.sdc_rd = 4'b0001;
    wait_busy();
    s0 = strobe_cnt;
    k  = 0;
    while (strobe_cnt - s0 < 100 && k < 5000) begin @(negedge clk_sys); k++; end
    chk("t6_reach_byte100", strobe_cnt - s0 >= 100, 1);
    d0 = done_cnt;
    #2 reset_n = 1'b0;
    #1 chk("t6_reset_outputs_zero", {bus.sdc_busy, bus.sdc_done, bus.sdc_err, bus.sdc_byte_in_strobe,
        bus.sdc_byte_in_addr, bus.sdc_byte_in_data, bus.mem_req, bus.mem_addr}, 0);
    exp_q.delete();
    exp_err_q.delete();
    armed = '{1, 1, 1, 1};
    bus.sdc_sector = 32'd0;
    expect_sector(0, 32'd0);
    repeat (2) @(negedge clk_sys);
    chk("t6_no_done_in_reset", done_cnt - d0, 0);
    reset_n = 1'b1;
    wait_busy();
    armed[0] = 0;
    wait_done();
    #1 chk("t6_restart_done", done_cnt - d0, 1);
    // randomized requests, sectors and memory latency
    rand_delay = 1;
    for (int it = 0; it < 4; it++) begin
      if ($urandom_range(0, 1) == 1) release_rd();
      for (int d = 0; d < 3; d++) sec[d] = $urandom_range(0, size[d] / 512);
      case ($urandom_range(0, 3))
        0: sec[3] = 32'd0;
        1: sec[3] = 32'h7FFFFE;
        2: sec[3] = 32'h7FFFFF;
        default: sec[3] = $urandom;
      endcase
      serve(4'($urandom_range(1, 15)));
      repeat (10) @(negedge clk_sys);
    end
    chk("final_queue_empty", exp_q.size() + exp_err_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
